// File: rtl/instr_cycle_sequencer.sv
// Multi-cycle instruction sequencer for the rv32i core: fetch/decode/execute/memory/writeback/update.
// Optional SINGLE_STEP_EN adds a step input that runs exactly one instruction from IDLE.
module instr_cycle_sequencer #(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  run,
`ifdef SINGLE_STEP_EN
   input  logic                  step,
`endif
   input  logic                  imem_ready,
   input  logic                  dmem_ready,
   input  logic                  is_load,
   input  logic                  is_store,
   input  logic                  writes_rd,
   output logic                  imem_req,
   output logic                  ir_load,
   output logic                  dmem_req,
   output logic                  dmem_we,
   output logic                  reg_write,
   output logic                  update_pc,
   output logic [2:0]            state,
   output logic [DATA_WIDTH-1:0] instret
);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_FETCH     = 3'd1;
   localparam logic [2:0] S_DECODE    = 3'd2;
   localparam logic [2:0] S_EXECUTE   = 3'd3;
   localparam logic [2:0] S_MEMORY    = 3'd4;
   localparam logic [2:0] S_WRITEBACK = 3'd5;
   localparam logic [2:0] S_UPDATE    = 3'd6;

   logic [2:0]            r_state;
   logic [2:0]            w_next;
   logic                  r_is_load;
   logic                  r_is_store;
   logic                  r_writes_rd;
   logic                  w_mem_we;
   logic                  r_imem_req;
   logic                  r_ir_load;
   logic                  r_dmem_req;
   logic                  r_dmem_we;
   logic                  r_reg_write;
   logic                  r_update_pc;
   logic [DATA_WIDTH-1:0] r_instret;
`ifdef SINGLE_STEP_EN
   logic                  r_step_mode;
   logic                  w_step_start;
`endif

   // Next-state decode; class inputs are only looked at while in EXECUTE.
   always_comb begin
      w_next = r_state;
`ifdef SINGLE_STEP_EN
      w_step_start = 1'b0;
`endif
      case (r_state)
         S_IDLE: begin
            if (run) begin
               w_next = S_FETCH;
            end
`ifdef SINGLE_STEP_EN
            else if (step) begin
               w_next       = S_FETCH;
               w_step_start = 1'b1;
            end
`endif
         end
         S_FETCH:     if (imem_ready) w_next = S_DECODE;
         S_DECODE:    w_next = S_EXECUTE;
         S_EXECUTE: begin
            if (is_load || is_store) w_next = S_MEMORY;
            else if (writes_rd)      w_next = S_WRITEBACK;
            else                     w_next = S_UPDATE;
         end
         S_MEMORY: begin
            if (dmem_ready) w_next = (r_is_load && r_writes_rd) ? S_WRITEBACK : S_UPDATE;
         end
         S_WRITEBACK: w_next = S_UPDATE;
         S_UPDATE: begin
`ifdef SINGLE_STEP_EN
            w_next = (run && !r_step_mode) ? S_FETCH : S_IDLE;
`else
            w_next = run ? S_FETCH : S_IDLE;
`endif
         end
         default:     w_next = S_IDLE;
      endcase
   end

   // Load wins when both class bits are set, so a store only writes if it is not also a load.
   assign w_mem_we = (r_state == S_EXECUTE) ? (is_store && !is_load) : r_is_store;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_is_load   <= 1'b0;
         r_is_store  <= 1'b0;
         r_writes_rd <= 1'b0;
      end else if (r_state == S_EXECUTE) begin
         r_is_load   <= is_load;
         r_is_store  <= is_store && !is_load;
         r_writes_rd <= writes_rd;
      end
   end

`ifdef SINGLE_STEP_EN
   // Remembers that the current instruction was launched by step, forcing a return to IDLE.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_step_mode <= 1'b0;
      end else if (r_state == S_IDLE && w_next == S_FETCH) begin
         r_step_mode <= w_step_start;
      end
   end
`endif

   // Strobes are registered from next-state so update_pc is a clean flop output.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_imem_req  <= 1'b0;
         r_ir_load   <= 1'b0;
         r_dmem_req  <= 1'b0;
         r_dmem_we   <= 1'b0;
         r_reg_write <= 1'b0;
         r_update_pc <= 1'b0;
         r_instret   <= '0;
      end else begin
         r_imem_req  <= (w_next == S_FETCH);
         r_ir_load   <= (w_next == S_DECODE);
         r_dmem_req  <= (w_next == S_MEMORY);
         r_dmem_we   <= (w_next == S_MEMORY) && w_mem_we;
         r_reg_write <= (w_next == S_WRITEBACK);
         r_update_pc <= (w_next == S_UPDATE);
         if (w_next == S_UPDATE) begin
            r_instret <= r_instret + DATA_WIDTH'(1);
         end
      end
   end

   assign imem_req  = r_imem_req;
   assign ir_load   = r_ir_load;
   assign dmem_req  = r_dmem_req;
   assign dmem_we   = r_dmem_we;
   assign reg_write = r_reg_write;
   assign update_pc = r_update_pc;
   assign state     = r_state;
   assign instret   = r_instret;

endmodule

// File: tb/tb_instr_cycle_sequencer.sv
// Directed bench for instr_cycle_sequencer; a second 3-bit instance checks instret wrap.
module tb_instr_cycle_sequencer;

   localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXECUTE = 3'd3;
   localparam logic [2:0] S_MEMORY = 3'd4, S_WRITEBACK = 3'd5, S_UPDATE = 3'd6;
   // Strobe vector order: {imem_req, ir_load, dmem_req, dmem_we, reg_write, update_pc}
   localparam logic [5:0] O_NONE = 6'b000000, O_FETCH = 6'b100000, O_DEC = 6'b010000;
   localparam logic [5:0] O_LD = 6'b001000, O_ST = 6'b001100, O_WB = 6'b000010, O_UPD = 6'b000001;

   logic clk = 1'b0;
   logic reset, run, imem_ready, dmem_ready, is_load, is_store, writes_rd;
   logic imem_req, ir_load, dmem_req, dmem_we, reg_write, update_pc;
   logic [2:0]  state;
   logic [31:0] instret;
   logic imem_req_w, ir_load_w, dmem_req_w, dmem_we_w, reg_write_w, update_pc_w;
   logic [2:0]  state_w;
   logic [2:0]  instret_w;
`ifdef SINGLE_STEP_EN
   logic step = 1'b0;
   int   pulses;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   instr_cycle_sequencer #(.DATA_WIDTH(32)) dut (
      .clk(clk), .reset(reset), .run(run),
`ifdef SINGLE_STEP_EN
      .step(step),
`endif
      .imem_ready(imem_ready), .dmem_ready(dmem_ready),
      .is_load(is_load), .is_store(is_store), .writes_rd(writes_rd),
      .imem_req(imem_req), .ir_load(ir_load), .dmem_req(dmem_req), .dmem_we(dmem_we),
      .reg_write(reg_write), .update_pc(update_pc), .state(state), .instret(instret)
   );

   instr_cycle_sequencer #(.DATA_WIDTH(3)) dut_w (
      .clk(clk), .reset(reset), .run(run),
`ifdef SINGLE_STEP_EN
      .step(step),
`endif
      .imem_ready(imem_ready), .dmem_ready(dmem_ready),
      .is_load(is_load), .is_store(is_store), .writes_rd(writes_rd),
      .imem_req(imem_req_w), .ir_load(ir_load_w), .dmem_req(dmem_req_w), .dmem_we(dmem_we_w),
      .reg_write(reg_write_w), .update_pc(update_pc_w), .state(state_w), .instret(instret_w)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Drive inputs for one cycle, then check state and strobes after the edge.
   task automatic cyc(input logic imr, input logic dmr, input logic rn,
                      input logic [2:0] es, input logic [5:0] eo, input string tag);
      imem_ready = imr;
      dmem_ready = dmr;
      run        = rn;
      @(negedge clk);
      chk({tag, "_state"}, 32'(state), 32'(es));
      chk({tag, "_strobes"}, 32'({imem_req, ir_load, dmem_req, dmem_we, reg_write, update_pc}),
          32'(eo));
   endtask

   // One zero-wait ALU instruction without rd; ends in UPDATE.
   task automatic alu_instr(input string tag);
      cyc(1'b1, 1'b1, 1'b1, S_FETCH,   O_FETCH, tag);
      cyc(1'b1, 1'b1, 1'b1, S_DECODE,  O_DEC,   tag);
      cyc(1'b1, 1'b1, 1'b1, S_EXECUTE, O_NONE,  tag);
      cyc(1'b1, 1'b1, 1'b1, S_UPDATE,  O_UPD,   tag);
   endtask

   initial begin
      reset = 1'b1; run = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
      is_load = 1'b0; is_store = 1'b0; writes_rd = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_state", 32'(state), 32'(S_IDLE));
      chk("reset_strobes", 32'({imem_req, ir_load, dmem_req, dmem_we, reg_write, update_pc}), 0);
      chk("reset_instret", instret, 0);
      reset = 1'b0;
      cyc(1'b0, 1'b0, 1'b0, S_IDLE, O_NONE, "idle_hold");

      // Continuous ALU stream: 1,2,3,6 repeating, three retired after 12 cycles
      alu_instr("alu1");
      alu_instr("alu2");
      alu_instr("alu3");
      chk("alu_instret3", instret, 32'd3);
      cyc(1'b1, 1'b1, 1'b0, S_IDLE, O_NONE, "alu_stop");

      // Load with rd, imem wait 2, dmem wait 3; run dropped early; class inputs change in MEMORY
      is_load = 1'b1; writes_rd = 1'b1;
      cyc(1'b0, 1'b0, 1'b1, S_FETCH,     O_FETCH, "ld_f1");
      cyc(1'b0, 1'b0, 1'b0, S_FETCH,     O_FETCH, "ld_f2");
      cyc(1'b0, 1'b0, 1'b0, S_FETCH,     O_FETCH, "ld_f3");
      cyc(1'b1, 1'b0, 1'b0, S_DECODE,    O_DEC,   "ld_dec");
      cyc(1'b0, 1'b0, 1'b0, S_EXECUTE,   O_NONE,  "ld_ex");
      cyc(1'b0, 1'b0, 1'b0, S_MEMORY,    O_LD,    "ld_m1");
      is_load = 1'b0; writes_rd = 1'b0; is_store = 1'b1;
      cyc(1'b0, 1'b0, 1'b0, S_MEMORY,    O_LD,    "ld_m2");
      cyc(1'b0, 1'b0, 1'b0, S_MEMORY,    O_LD,    "ld_m3");
      cyc(1'b0, 1'b0, 1'b0, S_MEMORY,    O_LD,    "ld_m4");
      cyc(1'b0, 1'b1, 1'b0, S_WRITEBACK, O_WB,    "ld_wb");
      cyc(1'b0, 1'b0, 1'b0, S_UPDATE,    O_UPD,   "ld_upd");
      cyc(1'b0, 1'b0, 1'b0, S_IDLE,      O_NONE,  "ld_idle");
      chk("ld_instret", instret, 32'd4);

      // Load+store both set, no rd: treated as load, straight to UPDATE
      is_load = 1'b1; is_store = 1'b1; writes_rd = 1'b0;
      cyc(1'b1, 1'b1, 1'b1, S_FETCH,   O_FETCH, "ls_f");
      cyc(1'b1, 1'b1, 1'b1, S_DECODE,  O_DEC,   "ls_dec");
      cyc(1'b1, 1'b1, 1'b1, S_EXECUTE, O_NONE,  "ls_ex");
      cyc(1'b1, 1'b1, 1'b1, S_MEMORY,  O_LD,    "ls_mem");
      cyc(1'b1, 1'b1, 1'b1, S_UPDATE,  O_UPD,   "ls_upd");

      // Load+store both set with rd: WRITEBACK entered
      writes_rd = 1'b1;
      cyc(1'b1, 1'b1, 1'b1, S_FETCH,     O_FETCH, "lsr_f");
      cyc(1'b1, 1'b1, 1'b1, S_DECODE,    O_DEC,   "lsr_dec");
      cyc(1'b1, 1'b1, 1'b1, S_EXECUTE,   O_NONE,  "lsr_ex");
      cyc(1'b1, 1'b1, 1'b1, S_MEMORY,    O_LD,    "lsr_mem");
      cyc(1'b1, 1'b1, 1'b1, S_WRITEBACK, O_WB,    "lsr_wb");
      cyc(1'b1, 1'b1, 1'b1, S_UPDATE,    O_UPD,   "lsr_upd");

      // Pure store with writes_rd set: dmem_we=1, never WRITEBACK
      is_load = 1'b0;
      cyc(1'b1, 1'b1, 1'b1, S_FETCH,   O_FETCH, "st_f");
      cyc(1'b1, 1'b1, 1'b1, S_DECODE,  O_DEC,   "st_dec");
      cyc(1'b1, 1'b1, 1'b1, S_EXECUTE, O_NONE,  "st_ex");
      cyc(1'b1, 1'b1, 1'b1, S_MEMORY,  O_ST,    "st_mem");
      cyc(1'b1, 1'b1, 1'b1, S_UPDATE,  O_UPD,   "st_upd");

      // ALU with rd: 5 cycles through WRITEBACK
      is_store = 1'b0;
      cyc(1'b1, 1'b1, 1'b1, S_FETCH,     O_FETCH, "ar_f");
      cyc(1'b1, 1'b1, 1'b1, S_DECODE,    O_DEC,   "ar_dec");
      cyc(1'b1, 1'b1, 1'b1, S_EXECUTE,   O_NONE,  "ar_ex");
      cyc(1'b1, 1'b1, 1'b1, S_WRITEBACK, O_WB,    "ar_wb");
      cyc(1'b1, 1'b1, 1'b0, S_UPDATE,    O_UPD,   "ar_upd");
      cyc(1'b1, 1'b1, 1'b0, S_IDLE,      O_NONE,  "ar_idle");
      chk("mix_instret", instret, 32'd8);

      // Store with run dropped during MEMORY: completes, then stays idle
      is_store = 1'b1; writes_rd = 1'b0;
      cyc(1'b1, 1'b0, 1'b1, S_FETCH,   O_FETCH, "rd_f");
      cyc(1'b1, 1'b0, 1'b1, S_DECODE,  O_DEC,   "rd_dec");
      cyc(1'b1, 1'b0, 1'b1, S_EXECUTE, O_NONE,  "rd_ex");
      cyc(1'b1, 1'b0, 1'b1, S_MEMORY,  O_ST,    "rd_m1");
      cyc(1'b1, 1'b0, 1'b0, S_MEMORY,  O_ST,    "rd_m2");
      cyc(1'b1, 1'b1, 1'b0, S_UPDATE,  O_UPD,   "rd_upd");
      for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b0, S_IDLE, O_NONE, "rd_idle");
      chk("rd_instret", instret, 32'd9);

      // Async reset in the middle of a stalled MEMORY access
      cyc(1'b1, 1'b0, 1'b1, S_FETCH,   O_FETCH, "ar2_f");
      cyc(1'b1, 1'b0, 1'b1, S_DECODE,  O_DEC,   "ar2_dec");
      cyc(1'b1, 1'b0, 1'b1, S_EXECUTE, O_NONE,  "ar2_ex");
      cyc(1'b1, 1'b0, 1'b1, S_MEMORY,  O_ST,    "ar2_m1");
      #2 reset = 1'b1;
      #1;
      chk("async_state", 32'(state), 32'(S_IDLE));
      chk("async_dmem_req", 32'(dmem_req), 0);
      chk("async_dmem_we", 32'(dmem_we), 0);
      chk("async_instret", instret, 0);
      chk("async_instret_w", 32'(instret_w), 0);
      @(negedge clk);
      reset = 1'b0; run = 1'b0; is_store = 1'b0;
      cyc(1'b1, 1'b1, 1'b0, S_IDLE, O_NONE, "post_reset");

      // Counter wrap on the 3-bit instance: 7 then 0
      for (int i = 0; i < 7; i++) alu_instr("wrap");
      chk("wrap_7", 32'(instret_w), 32'd7);
      alu_instr("wrap8");
      chk("wrap_0", 32'(instret_w), 0);
      chk("wrap_main", instret, 32'd8);
      cyc(1'b1, 1'b1, 1'b0, S_IDLE, O_NONE, "wrap_stop");

`ifdef SINGLE_STEP_EN
      // One-cycle step pulse with run low retires exactly one instruction
      step = 1'b1;
      cyc(1'b1, 1'b1, 1'b0, S_FETCH,   O_FETCH, "step_f");
      step = 1'b0;
      cyc(1'b1, 1'b1, 1'b0, S_DECODE,  O_DEC,   "step_dec");
      cyc(1'b1, 1'b1, 1'b0, S_EXECUTE, O_NONE,  "step_ex");
      cyc(1'b1, 1'b1, 1'b0, S_UPDATE,  O_UPD,   "step_upd");
      pulses = 0;
      for (int i = 0; i < 20; i++) begin
         cyc(1'b1, 1'b1, 1'b0, S_IDLE, O_NONE, "step_idle");
         if (update_pc) pulses++;
      end
      chk("step_pulses", 32'(pulses), 0);
      chk("step_instret", instret, 32'd9);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/instr_cycle_sequencer.md
Name: instr_cycle_sequencer

Overview:
- Multi-cycle control FSM for the rv32i core.
- Steps each instruction through fetch, decode, execute, memory access, register writeback and PC update.
- Issues the memory request handshakes and the register-file write strobe.
- Generates the single glitch-free update_pc pulse that advances the program counter. Also keeps a retired-instruction counter.

Parameters:
- DATA_WIDTH, 32, width of instret counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- run  input  1  level; 1 = execute continuously, 0 = stop after the current instruction.
- imem_ready  input  1  instruction memory has data valid for the current request.
- dmem_ready  input  1  data memory has completed the current access.
- is_load  input  1  decoded instruction is a load; sampled in EXECUTE.
- is_store  input  1  decoded instruction is a store; sampled in EXECUTE.
- writes_rd  input  1  decoded instruction writes rd (rd != x0); sampled in EXECUTE.
- imem_req  output  1  instruction fetch request.
- ir_load  output  1  latch instruction register.
- dmem_req  output  1  data memory request.
- dmem_we  output  1  data memory write enable; valid only with dmem_req.
- reg_write  output  1  register-file write strobe.
- update_pc  output  1  program counter update pulse; used as a clock edge downstream.
- state  output  3  current state encoding, for debug.
- instret  output  DATA_WIDTH  retired-instruction count.

Behaviour:
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, UPDATE=6. Encoding 7 is illegal and goes to IDLE on the next clock.
- Reset, asynchronous at any time including mid-instruction:
  - state=IDLE; all strobes 0; instret=0.
  - No partial update_pc pulse. A pulse cut short by reset is permitted only as the falling edge of an already-started pulse.
- Every control output comes straight from a flop, loaded from next_state, so it is valid in the same cycle as its state. update_pc must never be combinationally decoded.
- IDLE: all outputs 0. run=1 -> FETCH.
- FETCH: imem_req=1.
  - imem_ready=1 at a clock edge -> DECODE.
  - Otherwise stay; there is no timeout.
- DECODE: ir_load=1 for exactly one cycle -> EXECUTE.
- EXECUTE: one cycle, all strobes 0. Sample the class inputs:
  - is_load or is_store -> MEMORY.
  - else writes_rd -> WRITEBACK.
  - else -> UPDATE.
  - If is_load and is_store are both 1, treat as load (dmem_we=0).
- MEMORY: dmem_req=1; dmem_we = latched is_store and not is_load.
  - dmem_req/dmem_we stay stable until dmem_ready=1 at an edge.
  - Then -> WRITEBACK if latched load and writes_rd, else -> UPDATE.
  - A store never enters WRITEBACK.
- WRITEBACK: reg_write=1 for exactly one cycle -> UPDATE.
- UPDATE:
  - update_pc=1 for exactly one cycle; instret increments by 1, wrapping at 2^DATA_WIDTH-1 -> 0.
  - run=1 -> FETCH; run=0 -> IDLE.
- run deasserted mid-instruction: the instruction completes through UPDATE, then IDLE. There is never a partial instruction.
- Class inputs are latched in EXECUTE. Changes after EXECUTE are ignored.
- Cycle cost with zero-wait memory (ready=1 in the first request cycle): ALU-no-rd 4, ALU-with-rd 5, store 5, load 6.
- Exactly one update_pc rising edge per retired instruction. update_pc is low for at least 3 cycles between pulses.

Optional Feature:
- Macro: SINGLE_STEP_EN.
- Defined:
  - Adds input step (1 bit).
  - In IDLE with run=0, a step=1 sample -> FETCH; that instruction completes and returns to IDLE regardless of run.
  - step held high retires one instruction per UPDATE->IDLE->FETCH round trip.
  - run=1 has priority over step.
- Undefined: no step port; IDLE leaves only on run=1.

Test Plan:
- Reset then run=1, is_load=is_store=writes_rd=0, imem_ready=1 constantly -> states 1,2,3,6 repeating; update_pc high 1 cycle in every 4; instret=3 after 12 cycles.
- Load, writes_rd=1, imem_ready delayed 2 cycles, dmem_ready delayed 3 cycles -> imem_req high 3 cycles, dmem_req high 4 cycles with dmem_we=0, reg_write one cycle, then a single update_pc; 11 cycles total.
- Store with is_load=is_store=1 -> dmem_we=0 and WRITEBACK entered iff writes_rd; with is_store only -> dmem_we=1, no reg_write.
- run dropped during MEMORY -> completes WRITEBACK/UPDATE, then IDLE; imem_req stays 0 afterwards; instret incremented once.
- Async reset asserted mid-MEMORY -> state=0, dmem_req=0, instret=0 immediately without a clock; preload instret=32'hFFFF_FFFF via forced state -> next UPDATE gives 0.
- SINGLE_STEP_EN defined, run=0, one-cycle step pulse -> exactly one update_pc pulse, then IDLE held for 20 cycles.
